mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_resp_array.sv | 23 ++
 rtl/mem_responder.sv | 150 +++++++++++++++
 tb/tb_mem_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// State encoding, word/stat widths, alignment mask, saturating increment.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int STAT_W = 16;
  localparam logic [1:0] ALIGN_OK = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word array behind the responder: synchronous write, combinational read.
// Ports: clk, we, addr (word index), wdata, rdata.
module mem_resp_array
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one fetch/load/store at a time, valid/ready
// on request and response, WAIT_CYCLES wait states before the response.
// Ports: clk, reset (sync, active-high), req_valid/req_ready/req_we/
// req_addr/req_wdata, resp_valid/resp_ready/resp_rdata/resp_err.
// Optional macro MEM_RESP_STATS_EN adds stat_reads/stat_writes/stat_errs.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_reads,
  output logic [STAT_W-1:0] stat_writes,
  output logic [STAT_W-1:0] stat_errs
`endif
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int WLOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_wdata;

  logic              accept;
  logic              commit;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic              cur_err;
  logic [WORD_W-1:0] arr_rdata;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // With zero wait states the commit happens on the accept edge itself,
  // so the live request feeds the array; otherwise the latched copy does.
  assign cur_we    = (state == IDLE) ? req_we    : lat_we;
  assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;

  assign cur_err = (cur_addr[1:0] != ALIGN_OK)
                 | ((cur_addr >> (DEPTH_LOG2 + 2)) != '0);

  mem_resp_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (commit & cur_we & ~cur_err),
    .addr (cur_addr[DEPTH_LOG2+1:2]),
    .wdata(cur_wdata),
    .rdata(arr_rdata)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_n = RESP;
          end else begin
            cnt_n   = CNT_W'(WLOAD);
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          commit  = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= cur_err;
        resp_rdata <= (cur_we | cur_err) ? '0 : arr_rdata;
      end else if ((state == RESP) && resp_ready) begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

`ifdef MEM_RESP_STATS_EN
  logic resp_hs;
  assign resp_hs = (state == RESP) & resp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_errs   <= '0;
    end else if (resp_hs) begin
      if (resp_err)    stat_errs   <= sat_inc(stat_errs);
      else if (lat_we) stat_writes <= sat_inc(stat_writes);
      else             stat_reads  <= sat_inc(stat_reads);
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: randomized traffic against a
// word-array model; second instance with zero wait states for streaming.
module tb_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        z_reset, z_req_valid, z_req_we, z_resp_ready;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_req_ready, z_resp_valid, z_resp_err;
  logic [31:0] z_resp_rdata;

`ifdef MEM_RESP_STATS_EN
  logic [15:0] st_rd, st_wr, st_er;
  logic [15:0] z_st_rd, z_st_wr, z_st_er;
  int          m_rd = 0, m_wr = 0, m_er = 0;
`endif

  mem_responder #(
    .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
`ifdef MEM_RESP_STATS_EN
    , .stat_reads(st_rd), .stat_writes(st_wr), .stat_errs(st_er)
`endif
  );

  mem_responder #(
    .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .reset(z_reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
`ifdef MEM_RESP_STATS_EN
    , .stat_reads(z_st_rd), .stat_writes(z_st_wr), .stat_errs(z_st_er)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m  [256];
  logic [31:0] zmem_m [256];

  // A byte address is legal when word aligned and inside the 1 KiB array.
  function automatic logic exp_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  task automatic model_op(input logic we, input logic [31:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] er_d, output logic ee);
    ee = exp_err(a);
    if (ee || we) er_d = 32'h0;
    else er_d = mem_m[a / 4];
    if (!ee && we) mem_m[a / 4] = wd;
`ifdef MEM_RESP_STATS_EN
    if (ee) m_er++;
    else if (we) m_wr++;
    else m_rd++;
`endif
  endtask

  // One complete transaction on the main instance. cyc counts cycles
  // from the accept edge until resp_valid is seen.
  task automatic xact(input logic we, input logic [31:0] a,
                      input logic [31:0] wd, output int cyc,
                      output logic [31:0] rd, output logic er,
                      output logic tmo);
    tmo = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
    if (req_ready !== 1'b1) tmo = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (resp_valid !== 1'b1) tmo = 1'b1;
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; z_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid);
    end
    checks++;
    if (resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata);
    end
    checks++;
    if (resp_err !== 1'b0) begin
      errors++; $display("FAIL reset_err got=%b exp=0", resp_err);
    end
    reset = 1'b0; z_reset = 1'b0;
  endtask

  task automatic test_fill();
    int cyc; logic [31:0] rd, ed, wd; logic er, ee, tmo;
    for (int i = 0; i < 256; i++) begin
      wd = $urandom;
      model_op(1'b1, i * 4, wd, ed, ee);
      xact(1'b1, i * 4, wd, cyc, rd, er, tmo);
      checks++;
      if (tmo || cyc != W + 1 || rd !== ed || er !== ee) begin
        errors++;
        $display("FAIL fill[%0d] cyc=%0d rd=%h err=%b exp cyc=%0d rd=%h err=%b",
                 i, cyc, rd, er, W + 1, ed, ee);
      end
    end
  endtask

  task automatic test_directed();
    int cyc; logic [31:0] rd, ed; logic er, ee, tmo;
    model_op(1'b1, 32'h10, 32'hDEADBEEF, ed, ee);
    xact(1'b1, 32'h10, 32'hDEADBEEF, cyc, rd, er, tmo);
    checks++;
    if (tmo || cyc != 3) begin
      errors++; $display("FAIL store_latency got=%0d exp=3", cyc);
    end
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL store_resp rd=%h err=%b exp 0/0", rd, er);
    end
    model_op(1'b0, 32'h10, 32'h0, ed, ee);
    xact(1'b0, 32'h10, 32'h0, cyc, rd, er, tmo);
    checks++;
    if (tmo || cyc != 3) begin
      errors++; $display("FAIL load_latency got=%0d exp=3", cyc);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL load_resp rd=%h err=%b exp deadbeef/0", rd, er);
    end
  endtask

  task automatic test_misaligned();
    int cyc; logic [31:0] rd, ed; logic er, ee, tmo;
    model_op(1'b0, 32'h12, 32'h0, ed, ee);
    xact(1'b0, 32'h12, 32'h0, cyc, rd, er, tmo);
    checks++;
    if (tmo || cyc != 3 || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL misaligned cyc=%0d rd=%h err=%b exp 3/0/1", cyc, rd, er);
    end
    model_op(1'b0, 32'h10, 32'h0, ed, ee);
    xact(1'b0, 32'h10, 32'h0, cyc, rd, er, tmo);
    checks++;
    if (tmo || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL after_misaligned rd=%h err=%b exp deadbeef/0", rd, er);
    end
  endtask

  task automatic test_out_of_range();
    int cyc; logic [31:0] rd, ed; logic er, ee, tmo;
    model_op(1'b1, 32'h400, 32'h12345678, ed, ee);
    xact(1'b1, 32'h400, 32'h12345678, cyc, rd, er, tmo);
    checks++;
    if (tmo || cyc != 3 || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_store cyc=%0d rd=%h err=%b exp 3/0/1", cyc, rd, er);
    end
    model_op(1'b0, 32'h0, 32'h0, ed, ee);
    xact(1'b0, 32'h0, 32'h0, cyc, rd, er, tmo);
    checks++;
    if (tmo || rd !== ed || rd === 32'h12345678 || er !== 1'b0) begin
      errors++; $display("FAIL alias_word0 rd=%h err=%b exp %h/0", rd, er, ed);
    end
  endtask

  task automatic test_random();
    int cyc; logic [31:0] a, rd, ed, wd; logic er, ee, tmo, we;
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 9))
        7:       a = $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
        8:       a = $urandom | 32'h0000_0400;
        9:       a = $urandom;
        default: a = $urandom_range(0, 255) * 4;
      endcase
      model_op(we, a, wd, ed, ee);
      xact(we, a, wd, cyc, rd, er, tmo);
      checks++;
      if (tmo || cyc != W + 1 || rd !== ed || er !== ee) begin
        errors++;
        $display("FAIL random[%0d] we=%b a=%h cyc=%0d rd=%h err=%b exp rd=%h err=%b",
                 n, we, a, cyc, rd, er, ed, ee);
      end
    end
  endtask

  task automatic test_hold();
    int cyc; logic [31:0] a, ed, r0; logic ee, e0;
    a = $urandom_range(0, 255) * 4;
    model_op(1'b0, a, 32'h0, ed, ee);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    r0 = resp_rdata; e0 = resp_err;
    checks++;
    if (resp_valid !== 1'b1 || r0 !== ed || e0 !== ee) begin
      errors++; $display("FAIL hold_first rd=%h err=%b exp %h/%b", r0, e0, ed, ee);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = i[0]; req_we = 1'bx; req_addr = 'x; req_wdata = 'x;
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== r0 || resp_err !== e0
          || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] v=%b rd=%h err=%b rdy=%b exp 1/%h/%b/0",
                 i, resp_valid, resp_rdata, resp_err, req_ready, r0, e0);
      end
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0
        || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release v=%b rd=%h err=%b rdy=%b exp 0/0/0/1",
               resp_valid, resp_rdata, resp_err, req_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_ghost v=%b rdy=%b exp 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [31:0] rd, ed; logic er, ee, tmo;
    model_op(1'b1, 32'h20, 32'h11111111, ed, ee);
    xact(1'b1, 32'h20, 32'h11111111, cyc, rd, er, tmo);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_wdata = 32'h22222222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_accept rdy=%b exp 0", req_ready);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
`ifdef MEM_RESP_STATS_EN
    m_rd = 0; m_wr = 0; m_er = 0;
`endif
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state rdy=%b v=%b exp 1/0", req_ready, resp_valid);
    end
    model_op(1'b0, 32'h20, 32'h0, ed, ee);
    xact(1'b0, 32'h20, 32'h0, cyc, rd, er, tmo);
    checks++;
    if (tmo || rd !== 32'h11111111 || ed !== 32'h11111111 || er !== 1'b0) begin
      errors++; $display("FAIL midreset_data rd=%h err=%b exp 11111111/0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, wd, ed; logic we, ee;
    @(posedge clk); #1;
    z_req_valid = 1'b1;
    z_resp_ready = 1'b1;
    for (int n = 0; n < 48; n++) begin
      we = (n < 16);
      a  = (n < 16) ? n * 4 : $urandom_range(0, 15) * 4;
      if (n == 40) a = 32'h6;
      wd = $urandom;
      ee = exp_err(a);
      ed = (we || ee) ? 32'h0 : zmem_m[a / 4];
      if (!ee && we) zmem_m[a / 4] = wd;
      checks++;
      if (z_req_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d] got=%b exp 1", n, z_req_ready);
      end
      z_req_we = we; z_req_addr = a; z_req_wdata = wd;
      @(posedge clk); #1;
      checks++;
      if (z_resp_valid !== 1'b1 || z_req_ready !== 1'b0
          || z_resp_rdata !== ed || z_resp_err !== ee) begin
        errors++;
        $display("FAIL b2b[%0d] v=%b rdy=%b rd=%h err=%b exp 1/0/%h/%b",
                 n, z_resp_valid, z_req_ready, z_resp_rdata, z_resp_err, ed, ee);
      end
      @(posedge clk); #1;
    end
    z_req_valid = 1'b0;
    z_resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    z_reset = 1'b1; z_req_valid = 1'b0; z_req_we = 1'b0;
    z_req_addr = 32'h0; z_req_wdata = 32'h0; z_resp_ready = 1'b0;
    test_reset();
    test_fill();
    test_directed();
    test_misaligned();
    test_out_of_range();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_RESP_STATS_EN
    checks++;
    if (st_rd !== 16'(m_rd) || st_wr !== 16'(m_wr) || st_er !== 16'(m_er)) begin
      errors++;
      $display("FAIL stats rd=%0d wr=%0d er=%0d exp %0d/%0d/%0d",
               st_rd, st_wr, st_er, m_rd, m_wr, m_er);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
